// File: rtl/tcam_pkg.sv
// Shared constants, FSM state type and the lowest-set-bit encoder for the TCAM search block.
package tcam_pkg;

    localparam int SRAM_DW     = 32;
    localparam int SRAM_MASK_W = 4;
    // Widest match vector the priority encoder accepts; callers zero-extend into it.
    localparam int PRIO_MAX_W  = 1024;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        RESP   = 2'd2
    } tcam_state_e;

    // Index of the lowest set bit, 0 when the vector is all zero.
    function automatic logic [31:0] lowest_set(input logic [PRIO_MAX_W-1:0] vec);
        logic [31:0] idx;
        idx = '0;
        for (int i = PRIO_MAX_W - 1; i >= 0; i--) begin
            if (vec[i]) idx = 32'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/tcam_sram_1rw1r.sv
// Behavioural 1RW+1R SRAM with the sky130 macro pin-out: active-low csb/web, byte mask,
// reads registered at the output one cycle after the request.
module tcam_sram_1rw1r
    import tcam_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                   clk0,
    input  logic                   csb0,
    input  logic                   web0,
    input  logic [SRAM_MASK_W-1:0] wmask0,
    input  logic [ADDR_W-1:0]      addr0,
    input  logic [SRAM_DW-1:0]     din0,
    output logic [SRAM_DW-1:0]     dout0,
    input  logic                   clk1,
    input  logic                   csb1,
    input  logic [ADDR_W-1:0]      addr1,
    output logic [SRAM_DW-1:0]     dout1
);

    logic [SRAM_DW-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk0) begin
        if (!csb0) begin
            if (!web0) begin
                for (int b = 0; b < SRAM_MASK_W; b++) begin
                    if (wmask0[b]) mem[addr0][8*b +: 8] <= din0[8*b +: 8];
                end
            end else begin
                dout0 <= mem[addr0];
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (!csb1) dout1 <= mem[addr1];
    end

endmodule

// File: rtl/tcam_search_block.sv
// SRAM-backed TCAM search: a key fetches ENTRIES match bits, two 32-bit words per beat.
// Define TCAM_PRIO_ENC_EN to add the registered hit flag and lowest-matching-entry index.
module tcam_search_block
    import tcam_pkg::*;
#(
    parameter int QUERY_W = 7,
    parameter int ENTRIES = 64
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  wr_valid_i,
    output logic                                  wr_ready_o,
    input  logic [QUERY_W+$clog2(ENTRIES/32)-1:0] wr_addr_i,
    input  logic [SRAM_DW-1:0]                    wr_data_i,
    input  logic [SRAM_MASK_W-1:0]                wr_mask_i,
    input  logic                                  srch_valid_i,
    output logic                                  srch_ready_o,
    input  logic [QUERY_W-1:0]                    srch_query_i,
    output logic                                  rslt_valid_o,
    input  logic                                  rslt_ready_i,
`ifdef TCAM_PRIO_ENC_EN
    output logic                                  rslt_hit_o,
    output logic [$clog2(ENTRIES)-1:0]            rslt_idx_o,
`endif
    output logic [ENTRIES-1:0]                    rslt_match_o
);

    localparam int WORDS  = ENTRIES / 32;
    localparam int BEATS  = WORDS / 2;
    localparam int WIDX_W = $clog2(WORDS);
    localparam int ROW_W  = QUERY_W + WIDX_W;
    localparam int CNT_W  = $clog2(BEATS + 1);

    tcam_state_e          state_q, state_d;
    logic [QUERY_W-1:0]   query_q, query_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ENTRIES-1:0]   match_q, match_d;

    logic                 sram_csb0, sram_web0, sram_csb1;
    logic [ROW_W-1:0]     sram_addr0, sram_addr1;
    logic [SRAM_DW-1:0]   sram_dout0, sram_dout1;

    logic                 idle, wr_fire, srch_fire, last_beat, issue;
    logic [CNT_W-1:0]     issue_beat;
    logic [QUERY_W-1:0]   issue_query;
    logic [WIDX_W-1:0]    issue_word;

    assign idle         = (state_q == IDLE);
    assign wr_ready_o   = idle;
    // A write takes priority so a search in the following cycle sees the new data.
    assign srch_ready_o = idle & ~wr_valid_i;
    assign rslt_valid_o = (state_q == RESP);
    assign rslt_match_o = match_q;

    assign wr_fire   = idle & wr_valid_i;
    assign srch_fire = srch_valid_i & srch_ready_o;
    assign last_beat = (cnt_q == CNT_W'(BEATS));

    // cnt_q counts cycles since accept: it is the beat issuing now and one past the beat returning.
    assign issue       = srch_fire | ((state_q == SEARCH) & ~last_beat);
    assign issue_beat  = srch_fire ? '0 : cnt_q;
    assign issue_query = srch_fire ? srch_query_i : query_q;
    assign issue_word  = WIDX_W'({issue_beat, 1'b0});

    always_comb begin
        sram_csb0  = 1'b1;
        sram_web0  = 1'b1;
        sram_addr0 = {issue_word, issue_query};
        sram_csb1  = 1'b1;
        sram_addr1 = {issue_word | WIDX_W'(1), issue_query};
        if (wr_fire) begin
            sram_csb0  = 1'b0;
            sram_web0  = 1'b0;
            sram_addr0 = wr_addr_i;
        end else if (issue) begin
            sram_csb0 = 1'b0;
            sram_csb1 = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        query_d = query_q;
        cnt_d   = cnt_q;
        match_d = match_q;
        unique case (state_q)
            IDLE: begin
                if (srch_fire) begin
                    state_d = SEARCH;
                    query_d = srch_query_i;
                    cnt_d   = CNT_W'(1);
                end
            end
            SEARCH: begin
                match_d[(int'(cnt_q) - 1) * 64 +: 64] = {sram_dout1, sram_dout0};
                if (last_beat) state_d = RESP;
                else           cnt_d   = cnt_q + 1'b1;
            end
            RESP: begin
                if (rslt_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            query_q <= '0;
            cnt_q   <= '0;
            match_q <= '0;
        end else begin
            state_q <= state_d;
            query_q <= query_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
        end
    end

`ifdef TCAM_PRIO_ENC_EN
    localparam int IDX_W = $clog2(ENTRIES);

    logic             hit_q, hit_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             enter_resp;

    // Encoded from the completed vector so hit/idx land together with the match bits.
    assign enter_resp = (state_q == SEARCH) & last_beat;
    assign hit_d      = |match_d;
    assign idx_d      = IDX_W'(lowest_set(PRIO_MAX_W'(match_d)));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_q <= 1'b0;
            idx_q <= '0;
        end else if (enter_resp) begin
            hit_q <= hit_d;
            idx_q <= idx_d;
        end
    end

    assign rslt_hit_o = hit_q;
    assign rslt_idx_o = idx_q;
`endif

    tcam_sram_1rw1r #(
        .ADDR_W (ROW_W)
    ) u_sram (
        .clk0   (clk_i),
        .csb0   (sram_csb0),
        .web0   (sram_web0),
        .wmask0 (wr_mask_i),
        .addr0  (sram_addr0),
        .din0   (wr_data_i),
        .dout0  (sram_dout0),
        .clk1   (clk_i),
        .csb1   (sram_csb1),
        .addr1  (sram_addr1),
        .dout1  (sram_dout1)
    );

endmodule

// File: tb/tb_tcam_search_block.sv
// Bench: a 128-entry/4-bit-key instance under random traffic against a memory model,
// plus a default 64-entry instance for the fixed-vector and byte-mask cases.
module tb_tcam_search_block;

    localparam int QW    = 4;
    localparam int ENT   = 128;
    localparam int WORDS = ENT / 32;
    localparam int BEATS = WORDS / 2;
    localparam int ROW_W = QW + 2;
    localparam int ROWS  = 1 << ROW_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             wr_valid, wr_ready, srch_valid, srch_ready, rslt_valid, rslt_ready;
    logic [ROW_W-1:0] wr_addr;
    logic [31:0]      wr_data;
    logic [3:0]       wr_mask;
    logic [QW-1:0]    srch_query;
    logic [ENT-1:0]   rslt_match;

    logic             d_wr_valid, d_wr_ready, d_srch_valid, d_srch_ready, d_rslt_valid, d_rslt_ready;
    logic [7:0]       d_wr_addr;
    logic [31:0]      d_wr_data;
    logic [3:0]       d_wr_mask;
    logic [6:0]       d_srch_query;
    logic [63:0]      d_rslt_match;

`ifdef TCAM_PRIO_ENC_EN
    logic       rslt_hit, d_rslt_hit;
    logic [6:0] rslt_idx;
    logic [5:0] d_rslt_idx;
`endif

    tcam_search_block #(.QUERY_W(QW), .ENTRIES(ENT)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .wr_mask_i(wr_mask),
        .srch_valid_i(srch_valid), .srch_ready_o(srch_ready), .srch_query_i(srch_query),
        .rslt_valid_o(rslt_valid), .rslt_ready_i(rslt_ready),
`ifdef TCAM_PRIO_ENC_EN
        .rslt_hit_o(rslt_hit), .rslt_idx_o(rslt_idx),
`endif
        .rslt_match_o(rslt_match)
    );

    tcam_search_block u_dflt (
        .clk_i(clk), .rst_i(rst),
        .wr_valid_i(d_wr_valid), .wr_ready_o(d_wr_ready), .wr_addr_i(d_wr_addr),
        .wr_data_i(d_wr_data), .wr_mask_i(d_wr_mask),
        .srch_valid_i(d_srch_valid), .srch_ready_o(d_srch_ready), .srch_query_i(d_srch_query),
        .rslt_valid_o(d_rslt_valid), .rslt_ready_i(d_rslt_ready),
`ifdef TCAM_PRIO_ENC_EN
        .rslt_hit_o(d_rslt_hit), .rslt_idx_o(d_rslt_idx),
`endif
        .rslt_match_o(d_rslt_match)
    );

    logic [31:0] mem_m [ROWS];
    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_write(input int row, input logic [31:0] data, input logic [3:0] mask);
        for (int b = 0; b < 4; b++) if (mask[b]) mem_m[row][8*b +: 8] = data[8*b +: 8];
    endfunction

    function automatic logic [ENT-1:0] model_match(input int q);
        logic [ENT-1:0] m;
        for (int w = 0; w < WORDS; w++) m[w*32 +: 32] = mem_m[w * (1 << QW) + q];
        return m;
    endfunction

    function automatic int model_idx(input logic [ENT-1:0] m);
        for (int i = 0; i < ENT; i++) if (m[i]) return i;
        return 0;
    endfunction

    task automatic do_write(input int row, input logic [31:0] data, input logic [3:0] mask);
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = ROW_W'(row); wr_data = data; wr_mask = mask;
        #1 chk("wr_ready", wr_ready, 1);
        model_write(row, data, mask);
        @(posedge clk); #1 wr_valid = 1'b0;
    endtask

    // mode 0: plain; 1: write presented together with the search; 2: write presented while busy.
    task automatic do_search(input int q, input int stall, input int mode,
                             input int wrow, input logic [31:0] wdata, input logic [3:0] wmask);
        logic [ENT-1:0] exp;
        @(negedge clk);
        srch_valid = 1'b1; srch_query = QW'(q);
        if (mode == 1) begin
            wr_valid = 1'b1; wr_addr = ROW_W'(wrow); wr_data = wdata; wr_mask = wmask;
            #1 chk("coll_wr_ready", wr_ready, 1);
            chk("coll_srch_ready", srch_ready, 0);
            model_write(wrow, wdata, wmask);
            @(negedge clk); wr_valid = 1'b0;
        end
        #1 chk("srch_ready", srch_ready, 1);
        exp = model_match(q);
        @(posedge clk); #1 srch_valid = 1'b0;
        if (mode == 2) begin
            wr_valid = 1'b1; wr_addr = ROW_W'(wrow); wr_data = wdata; wr_mask = wmask;
        end
        for (int c = 1; c <= BEATS; c++) begin
            @(negedge clk);
            chk("lat_valid_low", rslt_valid, 0);
            chk("busy_wr_ready", wr_ready, 0);
        end
        @(negedge clk);
        chk("rslt_valid", rslt_valid, 1);
        chk("rslt_match", rslt_match, exp);
`ifdef TCAM_PRIO_ENC_EN
        chk("rslt_hit", rslt_hit, |exp);
        chk("rslt_idx", rslt_idx, model_idx(exp));
`endif
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("hold_valid", rslt_valid, 1);
            chk("hold_match", rslt_match, exp);
            chk("hold_wr_ready", wr_ready, 0);
            chk("hold_srch_ready", srch_ready, 0);
        end
        rslt_ready = 1'b1;
        #1 chk("resp_srch_ready", srch_ready, 0);
        @(posedge clk); #1 rslt_ready = 1'b0;
        @(negedge clk);
        chk("idle_valid", rslt_valid, 0);
        chk("idle_wr_ready", wr_ready, 1);
        if (mode == 2) begin
            model_write(wrow, wdata, wmask);
            @(posedge clk); #1 wr_valid = 1'b0;
        end
    endtask

    task automatic d_write(input int row, input logic [31:0] data, input logic [3:0] mask);
        @(negedge clk);
        d_wr_valid = 1'b1; d_wr_addr = 8'(row); d_wr_data = data; d_wr_mask = mask;
        #1 chk("d_wr_ready", d_wr_ready, 1);
        @(posedge clk); #1 d_wr_valid = 1'b0;
    endtask

    task automatic d_search(input int q, input logic [63:0] exp);
        @(negedge clk);
        d_srch_valid = 1'b1; d_srch_query = 7'(q);
        #1 chk("d_srch_ready", d_srch_ready, 1);
        @(posedge clk); #1 d_srch_valid = 1'b0;
        @(negedge clk); chk("d_lat_valid_low", d_rslt_valid, 0);
        @(negedge clk); chk("d_rslt_valid", d_rslt_valid, 1);
        chk("d_rslt_match", d_rslt_match, exp);
`ifdef TCAM_PRIO_ENC_EN
        chk("d_rslt_hit", d_rslt_hit, 1);
        chk("d_rslt_idx", d_rslt_idx, 0);
`endif
        @(negedge clk); chk("d_idle", d_wr_ready, 1);
    endtask

    initial begin
        wr_valid = 0; wr_addr = '0; wr_data = '0; wr_mask = '0;
        srch_valid = 0; srch_query = '0; rslt_ready = 0;
        d_wr_valid = 0; d_wr_addr = '0; d_wr_data = '0; d_wr_mask = '0;
        d_srch_valid = 0; d_srch_query = '0; d_rslt_ready = 1;

        #2;
        chk("rst_valid", rslt_valid, 0);
        chk("rst_match", rslt_match, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_srch_ready", srch_ready, 1);
`ifdef TCAM_PRIO_ENC_EN
        chk("rst_hit", rslt_hit, 0);
        chk("rst_idx", rslt_idx, 0);
`endif
        @(negedge clk); @(negedge clk); rst = 1'b0;

        // Default configuration: fixed vector, then byte-masked overwrite of the low word.
        d_write(8'h05, 32'hDEADBEEF, 4'hF);
        d_write(8'h85, 32'h12345678, 4'hF);
        d_search(5, 64'h12345678_DEADBEEF);
        d_write(8'h05, 32'hFFFFFFFF, 4'hF);
        d_write(8'h05, 32'h00000000, 4'h2);
        d_search(5, 64'h12345678_FFFF00FF);

        // Fill the 128-entry memory so every search has a known answer.
        for (int r = 0; r < ROWS; r++) do_write(r, $urandom, 4'hF);

        // Only bit 127 set for key 9.
        for (int w = 0; w < WORDS - 1; w++) do_write(w * 16 + 9, 32'h0, 4'hF);
        do_write(3 * 16 + 9, 32'h80000000, 4'hF);
        do_search(9, 0, 0, 0, 32'h0, 4'h0);

        // Backpressure for 5 cycles with a write to the searched key stalled behind the result.
        do_search(3, 5, 2, 16 + 3, 32'hA5A5_5A5A, 4'hF);
        do_search(3, 0, 0, 0, 32'h0, 4'h0);

        // Write and search together: the write goes first, the search sees it.
        do_search(6, 1, 1, 6, 32'h0F0F_F0F0, 4'hF);

        // Reset the cycle after a search is accepted.
        @(negedge clk);
        srch_valid = 1'b1; srch_query = QW'(7);
        #1 chk("mid_srch_ready", srch_ready, 1);
        @(posedge clk); #1 srch_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        #1 chk("mid_rst_valid", rslt_valid, 0);
        chk("mid_rst_match", rslt_match, 0);
        chk("mid_rst_wr_ready", wr_ready, 1);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_valid", rslt_valid, 0);
        end
        do_search(7, 0, 0, 0, 32'h0, 4'h0);

        // Random mix of writes, searches and colliding write+search.
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0, 1: do_write($urandom_range(0, ROWS - 1), $urandom, 4'($urandom));
                2:    do_search($urandom_range(0, 15), $urandom_range(0, 3), 0, 0, 32'h0, 4'h0);
                default: do_search($urandom_range(0, 15), $urandom_range(0, 2), 1,
                                   $urandom_range(0, ROWS - 1), $urandom, 4'($urandom));
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
